// File: rtl/rca_result_accumulator_if.sv
// Sample and result handshake bundle for the RCA result accumulator.
// The DUT uses the slave modport; the upstream/downstream side uses master.
interface rca_result_accumulator_if #(
  parameter int unsigned ACC_W = 15
);
  real              sum_in [10:0];
  logic             in_valid;
  logic             in_ready;
  logic             clr;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum_in,
    output in_valid,
    output clr,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  sum_in,
    input  in_valid,
    input  clr,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/rca_result_accumulator.sv
// Slices the ripple-carry adder's xreal sum, waits for carry settling, and accumulates
// ACC_LEN signed samples per frame. Define RCA_ACC_MEAN_EN to output the frame mean instead.
module rca_result_accumulator #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ACC_LEN       = 16,
  parameter int unsigned ACC_W         = 15
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  real                     VDD,
  rca_result_accumulator_if.slave bus
);

  localparam int unsigned SUM_W = 11;
  localparam int unsigned SHIFT = $clog2(ACC_LEN);
  localparam int unsigned CNT_W = SHIFT + 1;
  localparam int unsigned SET_W = 8;

  // Elaboration-time parameter legality
  if (ACC_W != SUM_W + SHIFT) begin : g_bad_acc_w
    $error("ACC_W must equal 11 + log2(ACC_LEN)");
  end
  if ((ACC_LEN < 2) || (ACC_LEN > 256) || ((ACC_LEN & (ACC_LEN - 1)) != 0)) begin : g_bad_len
    $error("ACC_LEN must be a power of two in 2..256");
  end
  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SET_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        sample_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] out_q;
  logic                    in_ready_q;
  logic                    out_valid_q;

  logic [SUM_W-1:0]        slice_c;
  logic signed [ACC_W-1:0] acc_sum_c;
  logic signed [ACC_W-1:0] result_c;
  logic                    last_c;

  logic                    in_ready_nxt;
  logic                    out_valid_nxt;
  logic                    settle_load;
  logic                    settle_dec;
  logic                    acc_en;
  logic                    frame_done;

  // Threshold slicer against VDD/2; only consumed at the SAMPLE edge
  always_comb begin
    slice_c = '0;
    for (int i = 0; i < int'(SUM_W); i++) begin
      slice_c[i] = (bus.sum_in[i] > (0.5 * VDD));
    end
  end

  always_comb begin
    acc_sum_c = acc + {{(ACC_W - SUM_W){slice_c[SUM_W-1]}}, slice_c};
    last_c    = (sample_cnt == CNT_W'(ACC_LEN - 1));
  end

`ifdef RCA_ACC_MEAN_EN
  always_comb result_c = acc_sum_c >>> SHIFT;
`else
  always_comb result_c = acc_sum_c;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: begin
        if (bus.in_valid) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!bus.in_valid)          state_nxt = ST_WAIT;
        else if (settle_cnt == '0)  state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.in_valid && last_c) state_nxt = ST_OUT;
        else                        state_nxt = ST_WAIT;
      end
      ST_OUT: begin
        if (bus.out_ready) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
    if (bus.clr) state_nxt = ST_WAIT;
  end

  // Output/control decode; handshake flags are registered from the next state
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    settle_load   = 1'b0;
    settle_dec    = 1'b0;
    acc_en        = 1'b0;
    frame_done    = 1'b0;
    case (state)
      ST_WAIT:   settle_load = bus.in_valid;
      ST_SETTLE: settle_dec  = bus.in_valid && (settle_cnt != '0);
      ST_SAMPLE: acc_en      = bus.in_valid;
      ST_OUT:    frame_done  = bus.out_ready;
      default:   ;
    endcase
    in_ready_nxt  = (state_nxt == ST_SAMPLE);
    out_valid_nxt = (state_nxt == ST_OUT);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      acc         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.clr) begin
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      acc         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      if (settle_load) begin
        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
      end else if (settle_dec) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
      if (acc_en) begin
        acc        <= acc_sum_c;
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (last_c) out_q <= result_c;
      end
      if (frame_done) begin
        acc        <= '0;
        sample_cnt <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;

endmodule
